delay_chain_ctrl: RTL and testbench
===================================

Name: delay_chain_ctrl

Overview:
- Valid/ready flow controller for a LEN-stage enable-gated delay chain (data register reset to 0, `en`-gated shift, output taken from the last stage).
- Tracks a per-stage valid bit and drives the chain's `en`. Stalls the whole chain on downstream backpressure and gates `en` off when the chain is empty.
- Provides drain (quiesce) and flush (discard) sequencing for upstream control logic.
- Carries no data itself: the delay chain's `out` is valid exactly when this block's `out_valid` is 1.

Parameters:
- LEN, 4, depth of the controlled delay chain; must be >= 1 (elaboration error for LEN = 0).
- CW, $clog2(LEN+1), occupancy counter width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock, shared with the delay chain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an item on the chain `in` bus
- in_ready  out  1  controller accepts the item this cycle
- out_valid  out  1  chain `out` holds a valid item
- out_ready  in  1  downstream consumes the item
- chain_en  out  1  connect to the delay chain `en`
- drain_req  in  1  single-cycle request: stop accepting, empty the chain
- drain_done  out  1  single-cycle pulse when the drain completes
- flush  in  1  single-cycle request: discard all in-flight items
- occupancy  out  CW  number of valid items in the chain, 0..LEN
- busy  out  1  occupancy != 0 or state != RUN

Behaviour:
- Internal state:
  - vld[LEN-1:0] (vld[0] = first stage).
  - occ counter.
  - FSM {RUN, DRAIN, FLUSH}, all registered.
- Reset, synchronous, while rst = 1 at the edge:
  - vld = 0, occ = 0, state = RUN.
  - Outputs: out_valid 0, drain_done 0, busy 0, occupancy 0.
  - in_ready and chain_en are forced to 0 while rst is high.
  - Reset mid-operation discards all items without a drain_done pulse.
- Combinational signals:
  - stall = vld[LEN-1] & ~out_ready.
  - in_ready = (state == RUN) & ~stall.
  - in_fire = in_valid & in_ready.
  - chain_en = (state != FLUSH) & ~stall & ((occ != 0) | in_fire).
  - out_valid = vld[LEN-1].
  - out_fire = out_valid & out_ready.
- On chain_en = 1: vld <= {vld[LEN-2:0], in_fire}; for LEN = 1, vld[0] <= in_fire. When chain_en = 0, vld holds.
- Bubbles (in_valid = 0 while the chain is non-empty) advance as vld = 0 entries, so the chain never compacts.
- occ <= occ + in_fire - out_fire. Simultaneous in/out leaves occ unchanged. occ never exceeds LEN because a full chain with stall deasserts in_ready.
- Latency:
  - An item accepted in cycle t shows out_valid in cycle t+LEN if there is no stall. Each stall cycle adds one.
  - Throughput is 1 item/cycle with out_ready held high.
- FSM transitions:
  - RUN: flush -> FLUSH; else drain_req -> DRAIN. in_ready drops from the next cycle.
  - DRAIN:
    - in_ready = 0; the chain keeps advancing while occ != 0.
    - When registered occ == 0: drain_done = 1 for one cycle and return to RUN the same cycle.
    - If entered with occ == 0, drain_done pulses in the first DRAIN cycle.
    - drain_req while already in DRAIN is ignored.
  - FLUSH: entered from any state on flush.
    - At the entry edge: vld <= 0, occ <= 0.
    - For one cycle: in_ready = 0, chain_en = 0, drain_done = 0.
    - Then RUN. An aborted drain never pulses drain_done.
- Priority: rst > flush > drain_req. A flush and an in_fire in the same cycle drop the accepted item.
- The chain's data registers are not cleared by flush. Stale data is masked by out_valid = 0.

Test Plan:
- LEN=4, out_ready=1, items A,B,C on cycles 0,1,2 -> out_valid in cycles 4,5,6 with chain out = A,B,C; occupancy peaks at 3; chain_en = 0 from cycle 7.
- LEN=4, continuous input, out_ready=0 from cycle 5 for 3 cycles -> chain_en = 0, in_ready = 0, occupancy = 4 held; resuming out_ready restores 1 item/cycle with no loss or duplication.
- Input A, bubble, B (cycles 0,2) -> out_valid in cycles 4 and 6 only, with a 0 in cycle 5.
- 3 items in flight, drain_req pulse -> in_ready = 0 next cycle; all 3 items exit; drain_done pulses once on the cycle after occupancy reaches 0; in_ready = 1 afterwards.
- Flush with 2 in flight, and flush during DRAIN -> occupancy = 0 and out_valid = 0 next cycle; no drain_done; stale chain data never appears with out_valid = 1.
- Synchronous rst asserted mid-stream, and a LEN=1 build -> all outputs return to their reset values at the next edge; with LEN=1, latency is 1 cycle and stall/flush behave identically.

Source files
------------

// File: rtl/delay_chain_ctrl.sv
// ----------------------------------------------------------------------------
// delay_chain_ctrl
//
// Purpose:
//   Valid/ready flow controller for an external LEN-stage delay chain. The
//   chain has enable-gated shift registers whose contents reset to 0, and its
//   output is taken from the last stage. This block carries no data. It keeps
//   one valid bit per chain stage and drives the chain enable. It freezes the
//   chain on downstream backpressure and stops clocking it once it is empty.
//   It also sequences drain (quiesce) and flush (discard) requests from
//   upstream control logic.
//
// Ports:
//   clk         rising-edge clock, shared with the delay chain
//   rst         synchronous, active-high reset
//   in_valid    upstream presents an item on the chain input bus
//   in_ready    the item is accepted this cycle
//   out_valid   the chain output holds a valid item
//   out_ready   downstream consumes the item
//   chain_en    enable for the delay chain shift
//   drain_req   one-cycle request: stop accepting, let the chain empty
//   drain_done  one-cycle pulse when a drain completes
//   flush       one-cycle request: discard every in-flight item
//   occupancy   number of valid items in the chain, 0..LEN
//   busy        items in flight, or a drain/flush is in progress
// ----------------------------------------------------------------------------
module delay_chain_ctrl #(
    parameter int  LEN = 4,
    localparam int CW  = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          chain_en,
    input  logic          drain_req,
    output logic          drain_done,
    input  logic          flush,
    output logic [CW-1:0] occupancy,
    output logic          busy
);

    if (LEN < 1) begin : g_len_check
        $error("delay_chain_ctrl: LEN must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [LEN-1:0]  vld_q, vld_d;
    logic [LEN-1:0]  vld_shift;
    logic [CW-1:0]   occ_q, occ_d;
    logic            stall;
    logic            in_fire;
    logic            out_fire;
    logic            occ_nz;

    // Valid bits move in lockstep with the chain data. Idle input cycles
    // still enter a 0, so bubbles travel through and the chain never compacts.
    if (LEN == 1) begin : g_shift_one
        assign vld_shift = in_fire;
    end else begin : g_shift_many
        assign vld_shift = {vld_q[LEN-2:0], in_fire};
    end

    always_comb begin
        occ_nz     = (occ_q != '0);
        stall      = vld_q[LEN-1] & ~out_ready;
        in_ready   = ~rst & (state_q == ST_RUN) & ~stall;
        in_fire    = in_valid & in_ready;
        // An empty chain is not clocked. A stalled chain freezes as a whole,
        // so the item at the output stays put until downstream takes it.
        chain_en   = ~rst & (state_q != ST_FLUSH) & ~stall & (occ_nz | in_fire);
        out_valid  = vld_q[LEN-1];
        out_fire   = out_valid & out_ready;
        // A drain that coincides with a reset or a flush is abandoned, so
        // it must not report completion.
        drain_done = ~rst & ~flush & (state_q == ST_DRAIN) & ~occ_nz;
        busy       = occ_nz | (state_q != ST_RUN);
        occupancy  = occ_q;

        state_d = state_q;
        vld_d   = vld_q;
        occ_d   = occ_q + CW'(in_fire) - CW'(out_fire);
        if (chain_en) begin
            vld_d = vld_shift;
        end

        unique case (state_q)
            ST_RUN: begin
                if (drain_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!occ_nz) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Flush outranks drain and drops any item accepted in the same
        // cycle. Chain data is left in place because cleared valid bits
        // already mask it.
        if (flush) begin
            state_d = ST_FLUSH;
            vld_d   = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            vld_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_delay_chain_ctrl.sv
module tb_delay_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       drain_req;
    logic       flush;
    logic [7:0] din;

    logic       ir4, ov4, en4, dd4, bz4;
    logic [2:0] occ4;
    logic       ir1, ov1, en1, dd1, bz1;
    logic [0:0] occ1;

    logic [7:0] ch4 [4];
    logic [7:0] ch1;

    int tests   = 0;
    int fails   = 0;
    int step_no = 0;

    always #5 clk = ~clk;

    delay_chain_ctrl #(.LEN(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .out_valid(ov4), .out_ready(out_ready), .chain_en(en4),
        .drain_req(drain_req), .drain_done(dd4), .flush(flush),
        .occupancy(occ4), .busy(bz4)
    );

    delay_chain_ctrl #(.LEN(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .out_valid(ov1), .out_ready(out_ready), .chain_en(en1),
        .drain_req(drain_req), .drain_done(dd1), .flush(flush),
        .occupancy(occ1), .busy(bz1)
    );

    // The delay chains being controlled: data reset to 0, enable-gated shift.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) ch4[k] <= 8'h00;
            ch1 <= 8'h00;
        end else begin
            if (en4) begin
                ch4[0] <= din;
                for (int k = 1; k < 4; k++) ch4[k] <= ch4[k-1];
            end
            if (en1) ch1 <= din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance.
    task automatic s(input bit sel, input logic r, input logic iv, input logic [7:0] d,
                     input logic ordy, input logic dr, input logic fl,
                     input logic e_ir, input logic e_en, input logic e_ov,
                     input logic [7:0] e_dat, input int e_occ,
                     input logic e_dd, input logic e_bz);
        logic       o_ir, o_en, o_ov, o_dd, o_bz;
        logic [7:0] o_dat;
        logic [31:0] o_occ;
        rst = r; in_valid = iv; din = d; out_ready = ordy; drain_req = dr; flush = fl;
        @(negedge clk);
        step_no++;
        if (sel) begin
            o_ir = ir1; o_en = en1; o_ov = ov1; o_dd = dd1; o_bz = bz1;
            o_dat = ch1; o_occ = 32'(occ1);
        end else begin
            o_ir = ir4; o_en = en4; o_ov = ov4; o_dd = dd4; o_bz = bz4;
            o_dat = ch4[3]; o_occ = 32'(occ4);
        end
        chk("in_ready",   32'(o_ir), 32'(e_ir));
        chk("chain_en",   32'(o_en), 32'(e_en));
        chk("out_valid",  32'(o_ov), 32'(e_ov));
        chk("occupancy",  o_occ,     32'(e_occ));
        chk("drain_done", 32'(o_dd), 32'(e_dd));
        chk("busy",       32'(o_bz), 32'(e_bz));
        if (e_ov) chk("out_data", 32'(o_dat), 32'(e_dat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = 8'h00; out_ready = 1'b1;
        drain_req = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, in_ready/chain_en forced low while rst is high
        s(0,1,1,8'h00,1,0,0, 0,0,0,8'h00,0,0,0);
        s(1,1,1,8'h00,1,0,0, 0,0,0,8'h00,0,0,0);

        // A,B,C back to back, out_ready high
        s(0,0,1,8'hA1,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'hB2,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'hC3,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,3,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'hA1,3,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'hB2,2,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'hC3,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Bubble between two items
        s(0,0,1,8'hE5,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'hF6,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'hE5,2,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'hF6,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Continuous input with a 3-cycle backpressure window
        s(0,0,1,8'h10,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'h11,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'h12,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,0,1,8'h13,1,0,0, 1,1,0,8'h00,3,0,1);
        s(0,0,1,8'h14,1,0,0, 1,1,1,8'h10,4,0,1);
        s(0,0,1,8'h15,0,0,0, 0,0,1,8'h11,4,0,1);
        s(0,0,1,8'h15,0,0,0, 0,0,1,8'h11,4,0,1);
        s(0,0,1,8'h15,0,0,0, 0,0,1,8'h11,4,0,1);
        s(0,0,1,8'h15,1,0,0, 1,1,1,8'h11,4,0,1);
        s(0,0,1,8'h16,1,0,0, 1,1,1,8'h12,4,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'h13,4,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'h14,3,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'h15,2,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'h16,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Drain on an empty chain completes in the first DRAIN cycle
        s(0,0,0,8'h00,1,1,0, 1,0,0,8'h00,0,0,0);
        s(0,0,0,8'h00,1,0,0, 0,0,0,8'h00,0,1,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Drain with 3 in flight; a repeated drain_req during DRAIN is ignored
        s(0,0,1,8'h21,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'h22,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'h23,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,0,0,8'h00,1,1,0, 1,1,0,8'h00,3,0,1);
        s(0,0,1,8'h99,1,0,0, 0,1,1,8'h21,3,0,1);
        s(0,0,1,8'h99,1,1,0, 0,1,1,8'h22,2,0,1);
        s(0,0,1,8'h99,1,0,0, 0,1,1,8'h23,1,0,1);
        s(0,0,1,8'h99,1,0,0, 0,0,0,8'h00,0,1,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Flush with 2 in flight plus an item accepted in the flush cycle
        s(0,0,1,8'h31,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'h32,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'h33,1,0,1, 1,1,0,8'h00,2,0,1);
        s(0,0,1,8'h44,1,0,0, 0,0,0,8'h00,0,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);
        // New item pushes stale chain data through without exposing it
        s(0,0,1,8'h55,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,1,1,8'h55,1,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Flush aborting a drain: no drain_done
        s(0,0,1,8'h41,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'h42,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'h43,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,0,0,8'h00,1,1,0, 1,1,0,8'h00,3,0,1);
        s(0,0,0,8'h00,1,0,0, 0,1,1,8'h41,3,0,1);
        s(0,0,0,8'h00,1,0,1, 0,1,1,8'h42,2,0,1);
        s(0,0,0,8'h00,1,0,0, 0,0,0,8'h00,0,0,1);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);
        s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        // Synchronous reset mid-stream
        s(0,0,1,8'h51,1,0,0, 1,1,0,8'h00,0,0,0);
        s(0,0,1,8'h52,1,0,0, 1,1,0,8'h00,1,0,1);
        s(0,0,1,8'h53,1,0,0, 1,1,0,8'h00,2,0,1);
        s(0,1,1,8'h54,1,0,0, 0,0,0,8'h00,3,0,1);
        for (int i = 0; i < 5; i++) begin
            s(0,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);
        end

        // LEN = 1: one-cycle latency, stall, flush
        s(1,0,1,8'h61,1,0,0, 1,1,0,8'h00,0,0,0);
        s(1,0,1,8'h62,1,0,0, 1,1,1,8'h61,1,0,1);
        s(1,0,0,8'h00,0,0,0, 0,0,1,8'h62,1,0,1);
        s(1,0,0,8'h00,1,0,0, 1,1,1,8'h62,1,0,1);
        s(1,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);
        s(1,0,1,8'h63,1,0,0, 1,1,0,8'h00,0,0,0);
        s(1,0,0,8'h00,1,0,1, 1,1,1,8'h63,1,0,1);
        s(1,0,0,8'h00,1,0,0, 0,0,0,8'h00,0,0,1);
        s(1,0,0,8'h00,1,0,0, 1,0,0,8'h00,0,0,0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
